vram_scan_arbiter: RTL and testbench
====================================

Name: vram_scan_arbiter

Overview:
- Shares one single-port synchronous video RAM between two users: display scan-out, which has fixed priority, and a drawing/CPU writer.
- Sits between the VGA timing generator and the framebuffer RAM. Consumes the generator's pixelCnt/lineCnt and produces a registered 4-bit pixel colour for the DAC stage.
- 640x400 display, 4 pixels per 16-bit word, 160 words per line.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 400, visible lines per frame
- H_TOTAL, 800, pixel clocks per line
- V_TOTAL, 449, lines per frame
- PIX_W, 4, bits per pixel
- DATA_W, 16, RAM word width (4 pixels)
- ADDR_W, 16, RAM word address width

Ports:
- clock  in  1  pixel clock, shared with the timing generator
- reset  in  1  synchronous, active-high
- pixelCnt  in  10  current pixel count from the timing generator
- lineCnt  in  9  current line count from the timing generator
- wrReq  in  1  writer valid; wrAddr/wrData are held stable until wrAck
- wrAddr  in  ADDR_W  writer word address
- wrData  in  DATA_W  writer word data
- wrAck  out  1  write accepted this cycle (combinational)
- memEn  out  1  RAM enable (combinational)
- memWe  out  1  RAM write enable (combinational)
- memAddr  out  ADDR_W  RAM address (combinational)
- memWdata  out  DATA_W  RAM write data; equals wrData
- memRdata  in  DATA_W  RAM read data, valid the cycle after a read
- pixelColor  out  PIX_W  registered pixel colour

Behaviour:
- Clock/reset: one clock, `clock`. Reset is synchronous and active-high on `reset`.
- Reset values:
  - pixelColor=0, fetchBuf=0, activeWord=0, dispAddr=1.
  - Combinational outputs follow their inputs during reset, except memEn, memWe and wrAck, which are forced to 0.
- Fetch slots (display read): a fetch occurs when either
  - (a) pixelCnt==H_TOTAL-4 and (lineCnt<V_ACTIVE-1 or lineCnt==V_TOTAL-1), which fetches word 0 of the next line; or
  - (b) lineCnt<V_ACTIVE, pixelCnt<=H_ACTIVE-8 and pixelCnt[1:0]==0, which fetches words 1..159.
- In a fetch slot: memEn=1, memWe=0, memAddr=dispAddr, wrAck=0. dispAddr increments by 1 at the end of the cycle.
- Frame realign: at pixelCnt==H_TOTAL-5 with lineCnt==V_TOTAL-1, dispAddr is set to 0. This takes precedence over the increment.
- Read capture: the cycle after a fetch slot, fetchBuf <= memRdata.
- Word hand-off: at every cycle with pixelCnt[1:0]==3, activeWord <= fetchBuf.
- Pixel output:
  - Each cycle, if pixelCnt<H_ACTIVE and lineCnt<V_ACTIVE, pixelColor <= activeWord[PIX_W*pixelCnt[1:0] +: PIX_W]. Otherwise pixelColor <= 0.
  - Latency is one clock from the (pixelCnt, lineCnt) pair to its colour.
  - Pixel 4w+i of a line sits in word bits [4i+3:4i] (LSB pixel first).
- Writer, all non-fetch cycles:
  - memEn=wrReq, memWe=wrReq, memAddr=wrAddr, wrAck=wrReq. A transfer is the cycle where wrReq&&wrAck.
  - The writer is never stalled more than 1 consecutive cycle: during active lines it gets 3 of every 4 slots, and all cycles during blanking.
- Memory addressing: display word address = y*160+w. After reset, line 0 of the first frame shows 0 for pixels 0..3; all later frames are exact.
- Reset mid-frame: the counters and registers above return to their reset values. Correct display resumes from the first frame boundary after the timing generator restarts.
- Counts outside legal ranges (pixelCnt>=H_TOTAL, lineCnt>=V_TOTAL) do not occur; behaviour for them is don't-care.

Optional Feature:
- Macro: VRAM_DOUBLE_BUFFER_EN
- With the macro defined:
  - Adds ports swapReq (in, 1, pulse), frontBuf (out, 1, reset 0) and swapDone (out, 1, reset 0).
  - memAddr widens to ADDR_W+1 bits. Its MSB is frontBuf for display reads and ~frontBuf for writes, so the writer always draws to the back buffer.
  - swapReq sets swapPending (reset 0). At the frame-realign cycle, if swapPending is set: frontBuf toggles, swapPending clears, and swapDone pulses high for 1 cycle.
  - A swapReq arriving in the realign cycle itself is held for the next frame.
- Without the macro: these ports are absent and memAddr is ADDR_W bits.

Test Plan:
- Reset, then free-run 2 frames with RAM preloaded so word n = n[15:0]:
  - frame 2, line 0, pixels 0..3 = 0,0,0,0; pixels 4..7 = 1,0,0,0;
  - line 1, pixel 0 = word 160 nibble 0 = 0x0;
  - pixel (0,1) sampled at the cycle after pixelCnt=0, lineCnt=1.
- Hold wrReq=1 continuously during line 5:
  - wrAck low exactly at pixelCnt 0,4,...,632 and 796; high otherwise;
  - no two consecutive wrAck=0.
- Write wrAddr=0x0000, wrData=0xABCD during vertical blank, then view frame: pixels (0..3, line 0) = D, C, B, A.
- Assert reset at line 200, pixelCnt 300, for 1 cycle:
  - next cycle pixelColor=0 and dispAddr=1;
  - after the generator restarts, the frame following the first realign matches the golden image.
- With VRAM_DOUBLE_BUFFER_EN:
  - pulse swapReq mid-frame → frontBuf toggles at pixelCnt=795, lineCnt=448, and swapDone is high for exactly that 1 cycle;
  - writes then target MSB = new ~frontBuf.
- Pixels outside the active region (e.g. x=700, any line; any x, line 420) → pixelColor=0 regardless of RAM contents.

Source files
------------

// File: rtl/vram_scan_arbiter_if.sv
// rtl/vram_scan_arbiter_if.sv - writer request and framebuffer RAM bus (VRAM_DOUBLE_BUFFER_EN widens memAddr)
interface vram_scan_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
`ifdef VRAM_DOUBLE_BUFFER_EN
  localparam int MEM_ADDR_W = ADDR_W + 1;
`else
  localparam int MEM_ADDR_W = ADDR_W;
`endif

  logic                  wrReq;
  logic [ADDR_W-1:0]     wrAddr;
  logic [DATA_W-1:0]     wrData;
  logic                  wrAck;
  logic                  memEn;
  logic                  memWe;
  logic [MEM_ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0]     memWdata;
  logic [DATA_W-1:0]     memRdata;

  // master: the arbiter, which owns the RAM port and acknowledges the writer
  modport master (
    input  wrReq, wrAddr, wrData, memRdata,
    output wrAck, memEn, memWe, memAddr, memWdata
  );

  // slave: the writer plus the RAM itself
  modport slave (
    output wrReq, wrAddr, wrData, memRdata,
    input  wrAck, memEn, memWe, memAddr, memWdata
  );
endinterface

// File: rtl/vram_scan_arbiter.sv
// rtl/vram_scan_arbiter.sv - display-priority VRAM arbiter and pixel serialiser (VRAM_DOUBLE_BUFFER_EN adds page flipping)
module vram_scan_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 400,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 449,
  parameter int PIX_W    = 4,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [9:0]           pixelCnt,
  input  logic [8:0]           lineCnt,
  vram_scan_arbiter_if.master  bus,
`ifdef VRAM_DOUBLE_BUFFER_EN
  input  logic                 swapReq,
  output logic                 frontBuf,
  output logic                 swapDone,
`endif
  output logic [PIX_W-1:0]     pixelColor
);

  localparam logic [9:0] FETCH0_PX     = 10'(H_TOTAL - 4);
  localparam logic [9:0] REALIGN_PX    = 10'(H_TOTAL - 5);
  localparam logic [9:0] LAST_FETCH_PX = 10'(H_ACTIVE - 8);
  localparam logic [9:0] H_ACT         = 10'(H_ACTIVE);
  localparam logic [8:0] V_ACT         = 9'(V_ACTIVE);
  localparam logic [8:0] V_PRELAST     = 9'(V_ACTIVE - 1);
  localparam logic [8:0] V_LAST        = 9'(V_TOTAL - 1);

  logic              fetch;
  logic              realign;
  logic              fetch_d;
  logic [ADDR_W-1:0] disp_addr;
  logic [ADDR_W-1:0] word_addr;
  logic [DATA_W-1:0] fetch_buf;
  logic [DATA_W-1:0] active_word;

  // Word 0 of a line is fetched at the end of the previous line; words 1..159 every 4th pixel
  always_comb begin
    fetch = 1'b0;
    realign = 1'b0;
    if (pixelCnt == FETCH0_PX && (lineCnt < V_PRELAST || lineCnt == V_LAST))
      fetch = 1'b1;
    if (lineCnt < V_ACT && pixelCnt <= LAST_FETCH_PX && pixelCnt[1:0] == 2'b00)
      fetch = 1'b1;
    if (pixelCnt == REALIGN_PX && lineCnt == V_LAST)
      realign = 1'b1;
  end

  always_comb begin
    bus.memWdata = bus.wrData;
    bus.memEn    = 1'b0;
    bus.memWe    = 1'b0;
    bus.wrAck    = 1'b0;
    word_addr    = bus.wrAddr;
    if (fetch) begin
      bus.memEn = ~reset;
      word_addr = disp_addr;
    end else begin
      bus.memEn = bus.wrReq & ~reset;
      bus.memWe = bus.wrReq & ~reset;
      bus.wrAck = bus.wrReq & ~reset;
    end
  end

`ifdef VRAM_DOUBLE_BUFFER_EN
  logic swap_pending;

  // The page bit selects the front buffer for scan-out and the back buffer for the writer
  always_comb begin
    bus.memAddr = {(fetch ? frontBuf : ~frontBuf), word_addr};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      frontBuf     <= 1'b0;
      swapDone     <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      swapDone     <= realign & swap_pending;
      if (realign && swap_pending)
        frontBuf <= ~frontBuf;
      swap_pending <= swapReq | (swap_pending & ~realign);
    end
  end
`else
  always_comb begin
    bus.memAddr = word_addr;
  end
`endif

  // fetch_buf lands two cycles before the lane-3 hand-off, so active_word swaps cleanly
  always_ff @(posedge clock) begin
    if (reset) begin
      disp_addr   <= ADDR_W'(1);
      fetch_d     <= 1'b0;
      fetch_buf   <= '0;
      active_word <= '0;
      pixelColor  <= '0;
    end else begin
      fetch_d <= fetch;
      if (realign)
        disp_addr <= '0;
      else if (fetch)
        disp_addr <= disp_addr + ADDR_W'(1);
      if (fetch_d)
        fetch_buf <= bus.memRdata;
      if (pixelCnt[1:0] == 2'b11)
        active_word <= fetch_buf;
      if (pixelCnt < H_ACT && lineCnt < V_ACT)
        pixelColor <= active_word[PIX_W*pixelCnt[1:0] +: PIX_W];
      else
        pixelColor <= '0;
    end
  end

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// tb/tb_vram_scan_arbiter.sv - scoreboard bench for vram_scan_arbiter
module tb_vram_scan_arbiter;

  localparam int K_PIX = 0, K_ACK = 1, K_EN = 2, K_WE = 3, K_ADDR = 4, K_FRONT = 5, K_DONE = 6, K_RUN = 7;

  typedef struct {
    int cyc;
    int kind;
    int exp;
    int x;
    int y;
  } chk_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] pixelCnt;
  logic [8:0] lineCnt;
  logic [3:0] pixelColor;
`ifdef VRAM_DOUBLE_BUFFER_EN
  logic       swapReq;
  logic       frontBuf;
  logic       swapDone;
`endif

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   bench_front = 0;
  int   zrun = 0;
  int   max_run = 0;
  bit   watch = 1'b0;
  chk_t q[$];
  logic [15:0] gold_w [int];
  logic [15:0] ram [int];

  vram_scan_arbiter_if bus ();

  vram_scan_arbiter dut (
    .clock(clk),
    .reset(reset),
    .pixelCnt(pixelCnt),
    .lineCnt(lineCnt),
    .bus(bus),
`ifdef VRAM_DOUBLE_BUFFER_EN
    .swapReq(swapReq),
    .frontBuf(frontBuf),
    .swapDone(swapDone),
`endif
    .pixelColor(pixelColor)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: untouched words read back as their own low 16 address bits
  always @(posedge clk) begin
    int ra;
    ra = int'(bus.memAddr);
    if (bus.memEn) begin
      if (bus.memWe)
        ram[ra] = bus.memWdata;
      else
        bus.memRdata <= ram.exists(ra) ? ram[ra] : 16'(ra & 32'hFFFF);
    end
  end

  function automatic int rd_full(input int a);
`ifdef VRAM_DOUBLE_BUFFER_EN
    return bench_front * 65536 + a;
`else
    return a;
`endif
  endfunction

  function automatic int wr_full(input int a);
`ifdef VRAM_DOUBLE_BUFFER_EN
    return ((bench_front == 0) ? 65536 : 0) + a;
`else
    return a;
`endif
  endfunction

  function automatic int exp_pixel(input int x, input int y);
    int a;
    int w;
    if (x >= 640 || y >= 400)
      return 0;
    a = rd_full(y * 160 + x / 4);
    w = gold_w.exists(a) ? int'(gold_w[a]) : (a & 32'hFFFF);
    return (w >> (4 * (x % 4))) & 15;
  endfunction

  function automatic int actual(input int k);
    case (k)
      K_PIX:   return int'(pixelColor);
      K_ACK:   return int'(bus.wrAck);
      K_EN:    return int'(bus.memEn);
      K_WE:    return int'(bus.memWe);
      K_ADDR:  return int'(bus.memAddr);
`ifdef VRAM_DOUBLE_BUFFER_EN
      K_FRONT: return int'(frontBuf);
      K_DONE:  return int'(swapDone);
`endif
      K_RUN:   return max_run;
      default: return -1;
    endcase
  endfunction

  function automatic string kname(input int k);
    case (k)
      K_PIX:   return "pixelColor";
      K_ACK:   return "wrAck";
      K_EN:    return "memEn";
      K_WE:    return "memWe";
      K_ADDR:  return "memAddr";
      K_FRONT: return "frontBuf";
      K_DONE:  return "swapDone";
      K_RUN:   return "max_consecutive_stall";
      default: return "unknown";
    endcase
  endfunction

  task automatic push(input int c, input int k, input int e, input int x, input int y);
    chk_t t;
    t.cyc = c; t.kind = k; t.exp = e; t.x = x; t.y = y;
    q.push_back(t);
  endtask

  // Drive one pixel clock; inputs set beforehand apply to this same cycle
  task automatic step(input int x, input int y, input bit chk);
    pixelCnt = 10'(x);
    lineCnt  = 9'(y);
    if (chk)
      push(cyc + 1, K_PIX, exp_pixel(x, y), x, y);
    @(posedge clk);
    #1;
  endtask

  task automatic run_line(input int y, input int x0, input int x1, input bit chk);
    for (int x = x0; x <= x1; x++)
      step(x, y, chk);
  endtask

  always @(negedge clk) begin
    if (watch) begin
      if (!bus.wrAck) zrun = zrun + 1;
      else zrun = 0;
      if (zrun > max_run) max_run = zrun;
    end
  end

  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < q.size()) begin
      if (q[i].cyc <= cyc) begin
        n_checks = n_checks + 1;
        if (q[i].cyc < cyc) begin
          n_fail = n_fail + 1;
          $display("FAIL %s x=%0d y=%0d: required %0h expired unsampled at cycle %0d", kname(q[i].kind),
                   q[i].x, q[i].y, q[i].exp, q[i].cyc);
        end else if (actual(q[i].kind) != q[i].exp) begin
          n_fail = n_fail + 1;
          $display("FAIL %s x=%0d y=%0d: actual %0h, required %0h", kname(q[i].kind),
                   q[i].x, q[i].y, actual(q[i].kind), q[i].exp);
        end
        q.delete(i);
      end else begin
        i = i + 1;
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.wrReq = 1'b0;
    bus.wrAddr = 16'h0000;
    bus.wrData = 16'h0000;
`ifdef VRAM_DOUBLE_BUFFER_EN
    swapReq = 1'b0;
`endif
    step(799, 448, 0);

    // Reset: gated strobes, address follows writer, colour cleared
    bus.wrReq = 1'b1;
    bus.wrAddr = 16'h0042;
    push(cyc, K_ACK, 0, 799, 448);
    push(cyc, K_EN, 0, 799, 448);
    push(cyc, K_WE, 0, 799, 448);
    push(cyc, K_ADDR, wr_full(16'h0042), 799, 448);
    push(cyc + 1, K_PIX, 0, 799, 448);
    step(799, 448, 0);
    bus.wrReq = 1'b0;
    reset = 1'b0;

    // First frame after reset: pixels 0..3 of line 0 are blank, the rest exact
    for (int x = 0; x < 4; x++) begin
      push(cyc + 1, K_PIX, 0, x, 0);
      step(x, 0, 0);
    end
    run_line(0, 4, 799, 1);
    run_line(1, 0, 799, 1);
    run_line(2, 0, 799, 1);

    // Second frame via realign, lines 0..5, writer saturating line 5
    run_line(448, 790, 799, 1);
    for (int y = 0; y < 5; y++)
      run_line(y, 0, 799, 1);
    bus.wrReq = 1'b1;
    bus.wrAddr = 16'hFFF0;
    bus.wrData = 16'h1234;
    watch = 1'b1;
    for (int x = 0; x < 800; x++) begin
      push(cyc, K_ACK, ((x % 4 == 0 && x <= 632) || x == 796) ? 0 : 1, x, 5);
      step(x, 5, 1);
    end
    watch = 1'b0;
    push(cyc, K_RUN, 1, -1, 5);

    // Fetch-slot boundaries seen by the writer
    push(cyc, K_ACK, 0, 796, 398); step(796, 398, 0);
    push(cyc, K_ACK, 1, 796, 399); step(796, 399, 0);
    push(cyc, K_ACK, 0, 796, 448); step(796, 448, 0);
    push(cyc, K_ACK, 0, 632, 10);  step(632, 10, 0);
    push(cyc, K_ACK, 1, 636, 10);  step(636, 10, 0);
    push(cyc, K_ACK, 1, 0, 400);   step(0, 400, 0);
    bus.wrReq = 1'b0;

    // Vertical blank: blank colour and an unstalled write of word 0
    run_line(420, 0, 7, 1);
    bus.wrReq = 1'b1;
    bus.wrAddr = 16'h0000;
    bus.wrData = 16'hABCD;
    push(cyc, K_ACK, 1, 8, 420);
    push(cyc, K_WE, 1, 8, 420);
    push(cyc, K_ADDR, wr_full(0), 8, 420);
    gold_w[wr_full(0)] = 16'hABCD;
    step(8, 420, 1);
    bus.wrReq = 1'b0;
    run_line(420, 9, 15, 1);
    run_line(448, 790, 799, 1);
    run_line(0, 0, 799, 1);
    run_line(1, 0, 19, 1);

    // Reset in mid-frame, then recovery from the next frame boundary
    run_line(200, 296, 299, 0);
    reset = 1'b1;
    bus.wrReq = 1'b1;
    bus.wrAddr = 16'h1111;
    push(cyc, K_ACK, 0, 300, 200);
    push(cyc, K_EN, 0, 300, 200);
    push(cyc, K_WE, 0, 300, 200);
    push(cyc + 1, K_PIX, 0, 300, 200);
    step(300, 200, 0);
    reset = 1'b0;
    bus.wrReq = 1'b0;
    run_line(200, 301, 303, 0);
    push(cyc, K_EN, 1, 304, 200);
    push(cyc, K_ADDR, rd_full(1), 304, 200);
    step(304, 200, 0);
    run_line(0, 0, 9, 0);
    run_line(448, 790, 799, 1);
    run_line(0, 0, 799, 1);
    run_line(1, 0, 799, 1);

`ifdef VRAM_DOUBLE_BUFFER_EN
    run_line(200, 96, 99, 0);
    swapReq = 1'b1;
    step(100, 200, 0);
    swapReq = 1'b0;
    run_line(448, 790, 793, 0);
    push(cyc + 1, K_FRONT, 0, 794, 448);
    step(794, 448, 0);
    push(cyc + 1, K_FRONT, 1, 795, 448);
    push(cyc + 1, K_DONE, 1, 795, 448);
    step(795, 448, 0);
    bench_front = 1;
    push(cyc + 1, K_DONE, 0, 796, 448);
    push(cyc, K_ADDR, rd_full(0), 796, 448);
    step(796, 448, 0);
    bus.wrReq = 1'b1;
    bus.wrAddr = 16'h0005;
    push(cyc, K_ADDR, wr_full(5), 797, 448);
    step(797, 448, 0);
    bus.wrReq = 1'b0;
    run_line(448, 798, 799, 0);
    run_line(448, 790, 794, 0);
    swapReq = 1'b1;
    push(cyc + 1, K_FRONT, 1, 795, 448);
    push(cyc + 1, K_DONE, 0, 795, 448);
    step(795, 448, 0);
    swapReq = 1'b0;
    run_line(448, 796, 799, 0);
    run_line(448, 790, 794, 0);
    push(cyc + 1, K_FRONT, 0, 795, 448);
    push(cyc + 1, K_DONE, 1, 795, 448);
    step(795, 448, 0);
    bench_front = 0;
    run_line(448, 796, 799, 0);
`endif

    run_line(420, 0, 3, 0);
    if (q.size() != 0) begin
      n_fail = n_fail + q.size();
      $display("FAIL scoreboard: %0d queued checks never evaluated", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
